// File: rtl/cam_pkg.sv
// Shared types and elaboration helpers for the managed CAM.
package cam_pkg;

  // Write engine states; each request walks IDLE -> CLEAR -> SET -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SET   = 2'd2
  } cam_state_t;

  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int ENTRIES            = 2 ** ADDR_WIDTH_DEFAULT;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of slice tables needed to cover a key of data_width bits.
  function automatic int slice_count(input int data_width, input int slice_width);
    return (data_width + slice_width - 1) / slice_width;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// Priority encoder over a request vector; "HIGH" favours the lowest index, "LOW" the highest.
module cam_priority_encoder #(
  parameter int    WIDTH        = 32,
  parameter int    OUT_WIDTH    = 5,
  parameter string LSB_PRIORITY = "HIGH"
) (
  input  logic [WIDTH-1:0]     req,
  output logic [OUT_WIDTH-1:0] idx,
  output logic                 any
);

  // Later loop iterations override earlier ones, so scan order sets the winner.
  always_comb begin
    idx = '0;
    any = |req;
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = WIDTH - 1; i >= 0; i--) if (req[i]) idx = OUT_WIDTH'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++) if (req[i]) idx = OUT_WIDTH'(i);
    end
  end

endmodule

// File: rtl/cam_slice_table.sv
// One key slice: a row per slice value, each row a one-hot-per-entry bit vector.
// A row bit is set when that entry's stored data has this slice value.
module cam_slice_table #(
  parameter int SLICE_WIDTH = 4,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_en,
  input  logic [SLICE_WIDTH-1:0]     clr_row,
  input  logic [ADDR_WIDTH-1:0]      clr_bit,
  input  logic                       set_en,
  input  logic [SLICE_WIDTH-1:0]     set_row,
  input  logic [ADDR_WIDTH-1:0]      set_bit,
  input  logic                       rd_en,
  input  logic [SLICE_WIDTH-1:0]     rd_row,
  output logic [2**ADDR_WIDTH-1:0]   rd_data
);

  localparam int ROWS = 2 ** SLICE_WIDTH;

  logic [2**ADDR_WIDTH-1:0] bits_q [ROWS];

  // Bit array update: clear and set never coincide in the write engine, set is applied last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) bits_q[r] <= '0;
    end else begin
      if (clr_en) bits_q[clr_row][clr_bit] <= 1'b0;
      if (set_en) bits_q[set_row][set_bit] <= 1'b1;
    end
  end

  // Registered row read, captured on search acceptance (pipeline stage 1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= bits_q[rd_row];
  end

endmodule

// File: rtl/cam_managed.sv
// Managed CAM: sliced match tables, 3-cycle write/delete engine, 2-stage search pipeline.
// Handshake: a request transfers on a rising edge where valid && ready are both high;
// inputs are sampled on that edge only. search_ready is high in IDLE; wr_ready also needs
// search_valid low, so a simultaneous search wins and the write transfers a later cycle.
module cam_managed
  import cam_pkg::*;
#(
  parameter int    DATA_WIDTH   = 128,
  parameter int    ADDR_WIDTH   = 5,
  parameter int    SLICE_WIDTH  = 4,
  parameter string LSB_PRIORITY = "HIGH"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_delete,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  search_valid,
  output logic                  search_ready,
  input  logic [DATA_WIDTH-1:0] search_key,
  output logic                  match_valid,
  output logic                  match,
  output logic                  multi_match,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic                  full,
  output cam_state_t            state_dbg
);

  localparam int N_ENTRIES = 2 ** ADDR_WIDTH;
  localparam int SLICES    = slice_count(DATA_WIDTH, SLICE_WIDTH);
  localparam int KEY_W     = SLICES * SLICE_WIDTH;

  cam_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [KEY_W-1:0]        lat_data;
  logic                    lat_delete;
  logic [KEY_W-1:0]        shadow [N_ENTRIES];
  logic [N_ENTRIES-1:0]    valid_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic                    wr_fire, search_fire, clr_en, set_en, s1_valid, enc_any;
  logic [KEY_W-1:0]        key_pad, old_data;
  logic [N_ENTRIES-1:0]    rows [SLICES];
  logic [N_ENTRIES-1:0]    hit_vec;
  logic [ADDR_WIDTH-1:0]   enc_idx;

  assign search_ready = (state_q == IDLE);
  assign wr_ready     = (state_q == IDLE) && !search_valid;
  assign wr_fire      = wr_valid && wr_ready;
  assign search_fire  = search_valid && search_ready;
  assign key_pad      = KEY_W'(search_key);
  assign old_data     = shadow[lat_addr];
  assign entry_count  = count_q;
  assign full         = (count_q == (ADDR_WIDTH + 1)'(N_ENTRIES));
  assign state_dbg    = state_q;

  // Write engine state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and table strobes: CLEAR drops the old row bits, SET installs the new ones.
  always_comb begin
    state_d = state_q;
    clr_en  = 1'b0;
    set_en  = 1'b0;
    case (state_q)
      IDLE:  if (wr_fire) state_d = CLEAR;
      CLEAR: begin
        clr_en  = valid_q[lat_addr];
        state_d = SET;
      end
      SET: begin
        set_en  = !lat_delete;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the write request on its transfer edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_delete <= 1'b0;
    end else if (wr_fire) begin
      lat_addr   <= wr_addr;
      lat_data   <= KEY_W'(wr_data);
      lat_delete <= wr_delete;
    end
  end

  // Shadow data, valid bits and occupancy all commit on the SET edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int e = 0; e < N_ENTRIES; e++) shadow[e] <= '0;
    end else if (state_q == SET) begin
      if (lat_delete) begin
        if (valid_q[lat_addr]) begin
          valid_q[lat_addr] <= 1'b0;
          count_q           <= count_q - 1'b1;
        end
      end else begin
        shadow[lat_addr] <= lat_data;
        if (!valid_q[lat_addr]) begin
          valid_q[lat_addr] <= 1'b1;
          count_q           <= count_q + 1'b1;
        end
      end
    end
  end

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    cam_slice_table #(
      .SLICE_WIDTH(SLICE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_table (
      .clk    (clk),
      .rst    (rst),
      .clr_en (clr_en),
      .clr_row(old_data[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .clr_bit(lat_addr),
      .set_en (set_en),
      .set_row(lat_data[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .set_bit(lat_addr),
      .rd_en  (search_fire),
      .rd_row (key_pad[s*SLICE_WIDTH +: SLICE_WIDTH]),
      .rd_data(rows[s])
    );
  end

  // An entry matches only if every slice row agrees.
  always_comb begin
    hit_vec = '1;
    for (int s = 0; s < SLICES; s++) hit_vec = hit_vec & rows[s];
  end

  cam_priority_encoder #(
    .WIDTH       (N_ENTRIES),
    .OUT_WIDTH   (ADDR_WIDTH),
    .LSB_PRIORITY(LSB_PRIORITY)
  ) u_enc (
    .req(hit_vec),
    .idx(enc_idx),
    .any(enc_any)
  );

  // Stage-1 valid tracks that the slice rows hold a fresh lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1_valid <= 1'b0;
    else      s1_valid <= search_fire;
  end

  // Stage 2: register the encoded result alongside a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_valid <= 1'b0;
      match       <= 1'b0;
      multi_match <= 1'b0;
      match_addr  <= '0;
    end else begin
      match_valid <= s1_valid;
      if (s1_valid) begin
        match       <= enc_any;
        multi_match <= |(hit_vec & (hit_vec - 1'b1));
        match_addr  <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_cam_managed.sv
// Directed bench for cam_managed: two instances (lowest-index and highest-index priority)
// share stimulus; a monitor pops expected results whenever a result strobe appears.
module tb_cam_managed;
  import cam_pkg::*;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int SW = 4;
  localparam int EW = 2 + 2 * AW;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic          wr_delete = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          search_valid = 1'b0;
  logic [DW-1:0] search_key = '0;

  logic wr_ready_h, search_ready_h, match_valid_h, match_h, multi_h, full_h;
  logic wr_ready_l, search_ready_l, match_valid_l, match_l, multi_l, full_l;
  logic [AW-1:0] addr_h, addr_l;
  logic [AW:0]   count_h, count_l;
  cam_state_t    state_h, state_l;

  cam_managed #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .LSB_PRIORITY("HIGH")) dut_h (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_h), .wr_delete(wr_delete),
    .wr_addr(wr_addr), .wr_data(wr_data), .search_valid(search_valid), .search_ready(search_ready_h),
    .search_key(search_key), .match_valid(match_valid_h), .match(match_h), .multi_match(multi_h),
    .match_addr(addr_h), .entry_count(count_h), .full(full_h), .state_dbg(state_h)
  );

  cam_managed #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .LSB_PRIORITY("LOW")) dut_l (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_l), .wr_delete(wr_delete),
    .wr_addr(wr_addr), .wr_data(wr_data), .search_valid(search_valid), .search_ready(search_ready_l),
    .search_key(search_key), .match_valid(match_valid_l), .match(match_l), .multi_match(multi_l),
    .match_addr(addr_l), .entry_count(count_l), .full(full_l), .state_dbg(state_l)
  );

  // Scoreboard state: {match, multi_match, addr_high_prio, addr_low_prio}
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every result strobe must match the oldest expected entry.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            a;
    if (match_valid_h || match_valid_l) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_strobe", "got a result strobe, required none");
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("strobe_pair", {30'd0, match_valid_h, match_valid_l}, 32'd3);
        check("latency", cyc - a, 2);
        check("match_h", match_h, e[EW-1]);
        check("multi_h", multi_h, e[EW-2]);
        check("addr_h",  addr_h,  e[2*AW-1:AW]);
        check("match_l", match_l, e[EW-1]);
        check("multi_l", multi_l, e[EW-2]);
        check("addr_l",  addr_l,  e[AW-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_delete = del;
    #1;
    while (!wr_ready_h && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!wr_ready_h) fail_now("wr_accept", "wr_ready stayed low past 20 cycles");
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_search(input logic [DW-1:0] key, input logic m, input logic mm,
                           input logic [AW-1:0] ah, input logic [AW-1:0] al,
                           input logic push, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    search_valid = 1'b1; search_key = key;
    #1;
    while (!search_ready_h && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!search_ready_h) fail_now("search_accept", "search_ready stayed low past 20 cycles");
    @(posedge clk);
    if (push) begin
      exp_q.push_back({m, mm, ah, al});
      acc_q.push_back(cyc);
    end
    #1;
    if (!keep) search_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !wr_ready_h) && n < 30) begin
      @(negedge clk); #1; n++;
    end
    if (exp_q.size() != 0) fail_now("drain", "expected results still pending after 30 cycles");
    if (!wr_ready_h) fail_now("engine_idle", "write engine busy after 30 cycles");
  endtask

  task automatic check_count(input string name, input int exp_cnt, input logic exp_full);
    check({name, "_count_h"}, count_h, exp_cnt);
    check({name, "_count_l"}, count_l, exp_cnt);
    check({name, "_full_h"},  full_h,  exp_full);
    check({name, "_full_l"},  full_l,  exp_full);
  endtask

  initial begin
    int busy;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int busy;
    repeat (3) @(negedge clk);
    #1;
    check("rst_match_valid", match_valid_h, 0);
    check("rst_match", match_h, 0);
    check("rst_addr", addr_h, 0);
    check("rst_state", state_h, IDLE);
    check_count("rst", 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single entry hit
    do_write(2'd3, 16'hA5A5, 1'b0);
    do_search(16'hA5A5, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0);
    drain();
    check_count("one", 1, 1'b0);

    // Duplicate data in entries 1 and 2
    do_write(2'd1, 16'h1234, 1'b0);
    do_write(2'd2, 16'h1234, 1'b0);
    do_search(16'h1234, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0);
    drain();
    check_count("three", 3, 1'b0);

    // Overwrite entry 3; back-to-back searches
    do_write(2'd3, 16'h0F0F, 1'b0);
    do_search(16'hA5A5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    do_search(16'h0F0F, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0);
    drain();
    check_count("overwrite", 3, 1'b0);

    // Delete entry 1, then delete it again as a no-op
    do_write(2'd1, 16'h0000, 1'b1);
    drain();
    check_count("delete", 2, 1'b0);
    do_search(16'h1234, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0);
    drain();
    do_write(2'd1, 16'h0000, 1'b1);
    busy = 1;
    while (!wr_ready_h && busy < 10) begin
      busy++;
      @(posedge clk); #1;
    end
    check("busy_cycles", busy, 3);
    check_count("redelete", 2, 1'b0);

    // Search and write collide in IDLE: search first, write next cycle
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 16'hBEEF; wr_delete = 1'b0;
    search_valid = 1'b1; search_key = 16'h1234;
    #1;
    check("collide_wr_ready", wr_ready_h, 0);
    check("collide_search_ready", search_ready_h, 1);
    @(posedge clk);
    exp_q.push_back({1'b1, 1'b0, 2'd2, 2'd2});
    acc_q.push_back(cyc);
    #1;
    search_valid = 1'b0;
    #1;
    check("collide_wr_ready_next", wr_ready_h, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("collide_state", state_h, CLEAR);
    drain();
    check_count("collide", 3, 1'b0);
    do_write(2'd1, 16'h5555, 1'b0);
    drain();
    check_count("full", 4, 1'b1);
    do_search(16'hBEEF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    do_search(16'h5555, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
    drain();

    // Reset during CLEAR
    do_write(2'd2, 16'h7777, 1'b0);
    check("pre_reset_state", state_h, CLEAR);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", state_h, IDLE);
    check_count("reset_write", 0, 1'b0);
    // Requests while in reset are ignored
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 16'h1234; wr_delete = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b1;
    drain();
    check_count("after_reset", 0, 1'b0);

    // Reset mid-search: no strobe for the discarded search
    do_write(2'd0, 16'h1234, 1'b0);
    drain();
    check_count("rebuild", 1, 1'b0);
    do_search(16'h1234, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_count("reset_search", 0, 1'b0);

    // Everything misses after reset
    do_search(16'h1234, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    do_search(16'h0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
    do_search(16'h7777, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
